// File: rtl/wb_s_mem_pkg.sv
// Shared types and constants for the Wishbone classic slave memory.
package wb_s_mem_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // Number of byte-offset address bits below the word index.
  function automatic int unsigned addr_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/wb_s_mem_ram.sv
// Byte-enabled word array with synchronous read and synchronous clear on rst.
module wb_s_mem_ram
  import wb_s_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic                    rd_clr,
  input  logic [DEPTH_LOG2-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned SEL_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (wr_en) begin
        for (int unsigned b = 0; b < SEL_W; b++) begin
          if (byte_en[b]) begin
            mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
      // Write and error responses present zero; reads capture the addressed word.
      if (rd_clr) begin
        rd_data_q <= '0;
      end else if (rd_en) begin
        rd_data_q <= mem_q[addr];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/wb_s_mem.sv
// Wishbone classic slave memory with configurable wait states before ack.
// Define WB_S_MEM_ERR_EN to answer out-of-range addresses with err_o.
module wb_s_mem
  import wb_s_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    ack_o,
  output logic                    err_o
);

  localparam int unsigned ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int unsigned SEL_W    = DATA_WIDTH / 8;
  localparam int unsigned IDX_HI   = DEPTH_LOG2 + ADDR_LSB;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    oor_q, oor_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    resp_enter_c;
  logic                    req_oor_c;
  logic                    unused_adr;

`ifdef WB_S_MEM_ERR_EN
  assign req_oor_c = |adr_i[ADDR_WIDTH-1:IDX_HI];
`else
  assign req_oor_c = 1'b0;
`endif

  // Byte-offset bits (and upper bits when aliasing) are intentionally ignored.
  assign unused_adr = ^adr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      oor_q   <= oor_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; the *_d request fields describe the transfer being answered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    idx_d        = idx_q;
    wdat_d       = wdat_q;
    sel_d        = sel_q;
    oor_d        = oor_q;
    resp_enter_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cyc_i && stb_i) begin
          we_d   = we_i;
          idx_d  = adr_i[IDX_HI-1:ADDR_LSB];
          wdat_d = dat_i;
          sel_d  = sel_i;
          oor_d  = req_oor_c;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d      = S_RESP;
            resp_enter_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!cyc_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d      = S_RESP;
          resp_enter_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ack_d = resp_enter_c && !oor_d;
    err_d = resp_enter_c && oor_d;
  end

  wb_s_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (resp_enter_c && we_d && !oor_d),
    .rd_en   (resp_enter_c && !we_d && !oor_d),
    .rd_clr  (resp_enter_c && (we_d || oor_d)),
    .addr    (idx_d),
    .wdata   (wdat_d),
    .byte_en (sel_d),
    .rd_data (dat_o)
  );

  assign ack_o = ack_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_wb_s_mem.sv
// Randomized self-checking bench for wb_s_mem against an array-based bus model.
module tb_wb_s_mem;

  localparam int unsigned WS      = 2;
  localparam int          TIMEOUT = 40;

  logic        clk;
  logic        rst;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [31:0] adr_i;
  logic [15:0] dat_i;
  logic [1:0]  sel_i;
  logic [15:0] dat_o;
  logic        ack_o;
  logic        err_o;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] mem_m [256];

  wb_s_mem #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (16),
    .DEPTH_LOG2  (8),
    .WAIT_STATES (WS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cyc_i (cyc_i),
    .stb_i (stb_i),
    .we_i  (we_i),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .sel_i (sel_i),
    .dat_o (dat_o),
    .ack_o (ack_o),
    .err_o (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bus-level expectation: what the slave must answer and how memory changes.
  task automatic model_xfer(input logic we, input logic [31:0] adr, input logic [15:0] dat,
                            input logic [1:0] sel, output logic e_ack, output logic e_err,
                            output logic [15:0] e_dat);
    int  idx;
    logic oor;
    idx = int'(adr[8:1]);
`ifdef WB_S_MEM_ERR_EN
    oor = (adr[31:9] != 23'd0);
`else
    oor = 1'b0;
`endif
    e_ack = !oor;
    e_err = oor;
    e_dat = 16'h0000;
    if (!oor) begin
      if (we) begin
        if (sel[0]) mem_m[idx][7:0]  = dat[7:0];
        if (sel[1]) mem_m[idx][15:8] = dat[15:8];
      end else begin
        e_dat = mem_m[idx];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
  endtask

  task automatic run_xfer(input string tag, input logic we, input logic [31:0] adr,
                          input logic [15:0] dat, input logic [1:0] sel);
    logic        e_ack, e_err, g_ack, g_err;
    logic [15:0] e_dat, g_dat;
    int          lat;
    model_xfer(we, adr, dat, sel, e_ack, e_err, e_dat);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    lat = 0; g_ack = 1'b0; g_err = 1'b0; g_dat = 16'h0000;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (ack_o || err_o) begin
        lat = k; g_ack = ack_o; g_err = err_o; g_dat = dat_o;
        break;
      end
      if (k == 1) begin
        we_i  = ~we_i;
        adr_i = $urandom;
        dat_i = 16'($urandom);
        sel_i = 2'($urandom);
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(WS + 1));
    check({tag, " ack"}, 32'(g_ack), 32'(e_ack));
    check({tag, " err"}, 32'(g_err), 32'(e_err));
    check({tag, " dat"}, 32'(g_dat), 32'(e_dat));
    @(negedge clk);
    check({tag, " pulse"}, 32'({ack_o, err_o}), 32'd0);
  endtask

  initial begin
    int          ack_pos[$];
    logic        e_ack, e_err;
    logic [15:0] e_dat;
    logic [31:0] a;
    logic        saw;

    rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = '0; dat_i = '0; sel_i = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset ack", 32'(ack_o), 32'd0);
    check("reset err", 32'(err_o), 32'd0);
    check("reset dat", 32'(dat_o), 32'd0);
    rst = 1'b0;

    run_xfer("rd_0004", 1'b0, 32'h0000_0004, 16'h0000, 2'b11);

    run_xfer("wr_beef", 1'b1, 32'h0000_0010, 16'hBEEF, 2'b11);
    run_xfer("wr_1234", 1'b1, 32'h0000_0010, 16'h1234, 2'b01);
    run_xfer("rd_be34", 1'b0, 32'h0000_0010, 16'h0000, 2'b11);
    check("merge const", 32'(mem_m[8]), 32'h0000_BE34);

    // Drop cyc_i in the last WAIT cycle: the write must vanish.
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h20; dat_i = 16'hAAAA; sel_i = 2'b11;
    saw = 1'b0;
    for (int k = 1; k <= int'(WS) + 4; k++) begin
      @(negedge clk);
      if (ack_o || err_o) saw = 1'b1;
      if (k == int'(WS)) cyc_i = 1'b0;
    end
    stb_i = 1'b0;
    check("abort no ack", 32'(saw), 32'd0);
    run_xfer("rd_abort", 1'b0, 32'h0000_0020, 16'h0000, 2'b11);

    // Strobe held through RESP: acks spaced WS+2 apart.
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h10; sel_i = 2'b11;
    for (int k = 1; k <= 3 * (int'(WS) + 2); k++) begin
      @(negedge clk);
      if (ack_o) begin
        ack_pos.push_back(k);
        check("b2b dat", 32'(dat_o), 32'(mem_m[8]));
      end
      if (ack_o && err_o) check("b2b excl", 32'd1, 32'd0);
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    check("b2b count", 32'(ack_pos.size()), 32'd3);
    foreach (ack_pos[i]) check("b2b pos", 32'(ack_pos[i]), 32'(int'(WS) + 1 + i * (int'(WS) + 2)));

    run_xfer("wr_oor", 1'b1, 32'h0000_0200, 16'h5555, 2'b11);
    run_xfer("rd_oor0", 1'b0, 32'h0000_0000, 16'h0000, 2'b11);

    // Reset during WAIT discards the write and clears everything.
    model_xfer(1'b1, 32'h0000_0002, 16'h7777, 2'b11, e_ack, e_err, e_dat);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h2; dat_i = 16'h7777; sel_i = 2'b11;
    @(negedge clk);
    rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk);
    check("rst mid ack", 32'(ack_o), 32'd0);
    check("rst mid err", 32'(err_o), 32'd0);
    check("rst mid dat", 32'(dat_o), 32'd0);
    rst = 1'b0;
    model_clear();
    saw = 1'b0;
    repeat (int'(WS) + 3) begin
      @(negedge clk);
      if (ack_o || err_o) saw = 1'b1;
    end
    check("rst no ack", 32'(saw), 32'd0);
    run_xfer("rd_rst", 1'b0, 32'h0000_0002, 16'h0000, 2'b11);
    run_xfer("rd_alias", 1'b0, 32'h0000_0000, 16'h0000, 2'b11);

    // Random traffic with idle gaps carrying a stray strobe without cyc_i.
    for (int t = 0; t < 60; t++) begin
      a = {($urandom_range(0, 5) == 0) ? 23'($urandom) : 23'd0, 9'($urandom_range(0, 63))};
      run_xfer("rand", 1'($urandom), a, 16'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 2)) begin
        stb_i = 1'($urandom);
        @(negedge clk);
        check("stray stb", 32'({ack_o, err_o}), 32'd0);
      end
      stb_i = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
